// File: rtl/pmu_bitstream_word_assembler.sv
// Serial-to-parallel bitstream packer: shifts bits MSB first into WORD_WIDTH-bit words and
// queues completed words in a small FIFO with a valid/ready output and framing status.
module pmu_bitstream_word_assembler #(
    parameter int unsigned WORD_WIDTH = 40,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  sync_i,
    input  logic                  bit_i,
    input  logic                  bit_valid_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic [5:0]            bit_cnt_o,
    output logic [CNT_WIDTH-1:0]  words_o,
    output logic                  overflow_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [5:0] LastBit = 6'(WORD_WIDTH - 1);
    localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StAssemble} state_e;

    state_e                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  shreg_q, shreg_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]  push_word;
    logic                   push;

    logic [WORD_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]          count_q, count_d;
    logic [CNT_WIDTH-1:0]   words_q;
    logic                   overflow_q;
    logic                   pop, push_ok, drop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (en_i)  state_d = StAssemble;
            StAssemble: if (!en_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Shifter: sync and disable both discard the partial word; sync beats completion.
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_word = {shreg_q[WORD_WIDTH-2:0], bit_i};
        if (state_q != StAssemble || !en_i || sync_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (bit_valid_i) begin
            if (cnt_q == LastBit) begin
                push    = 1'b1;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = push_word;
                cnt_d   = cnt_q + 6'd1;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        pop     = (count_q != '0) && data_ready_i;
        push_ok = push && ((count_q != FifoFull) || pop);
        drop    = push && !push_ok;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            words_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
                if (words_q != '1) begin
                    words_q <= words_q + CNT_WIDTH'(1);
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign data_o       = mem_q[rd_ptr_q];
    assign data_valid_o = (count_q != '0);
    assign bit_cnt_o    = cnt_q;
    assign words_o      = words_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_pmu_bitstream_word_assembler.sv
// Self-checking bench: constant vector table, directed multi-cycle sequences and random
// stimulus, all compared against a queue-based reference model of the assembler.
module tb_pmu_bitstream_word_assembler;

    logic        clk = 1'b0;
    logic        rst, en_i, sync_i, bit_i, bit_valid_i, data_ready_i;
    logic [39:0] data_o;
    logic        data_valid_o;
    logic [5:0]  bit_cnt_o;
    logic [15:0] words_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    pmu_bitstream_word_assembler #(
        .WORD_WIDTH(40),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .sync_i      (sync_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .bit_cnt_o   (bit_cnt_o),
        .words_o     (words_o),
        .overflow_o  (overflow_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: partial word as a number, FIFO as a queue.
    bit          m_asm;
    int          m_bits;
    logic [39:0] m_part;
    logic [39:0] m_q[$];
    int          m_words;
    bit          m_ovf;

    function automatic void model_step();
        bit          pop, full, push;
        logic [39:0] word;
        if (rst) begin
            m_asm = 0; m_bits = 0; m_part = '0; m_q.delete(); m_words = 0; m_ovf = 0;
            return;
        end
        pop  = (m_q.size() > 0) && data_ready_i;
        full = (m_q.size() == 4);
        push = 0;
        word = '0;
        if (m_asm) begin
            if (!en_i || sync_i) begin
                m_bits = 0; m_part = '0;
            end else if (bit_valid_i) begin
                m_part = m_part * 2 + 40'(bit_i);
                m_bits = m_bits + 1;
                if (m_bits == 40) begin
                    push = 1; word = m_part; m_bits = 0; m_part = '0;
                end
            end
        end
        m_asm = en_i;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) begin
                m_q.push_back(word);
                if (m_words < 65535) m_words++;
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_model();
        check("valid", 64'(data_valid_o), 64'(m_q.size() > 0));
        check("bit_cnt", 64'(bit_cnt_o), 64'(m_bits));
        check("words", 64'(words_o), 64'(m_words));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        if (m_q.size() > 0) check("data", 64'(data_o), 64'(m_q[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic shift_word(input logic [39:0] w);
        bit_valid_i = 1;
        for (int i = 39; i >= 0; i--) begin
            bit_i = w[i];
            tick();
        end
        bit_valid_i = 0;
    endtask

    task automatic do_reset();
        rst = 1; en_i = 0; sync_i = 0; bit_valid_i = 0; bit_i = 0;
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic       rst, en, sync, b, bv, rdy;
        logic       valid;
        logic [5:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t        tbl[9];
    logic [39:0] w[5];
    localparam logic [39:0] WordA = 40'h0000C000AA;
    localparam logic [39:0] WordB = 40'hC000000710;

    initial begin
        rst = 1; en_i = 0; sync_i = 0; bit_i = 0; bit_valid_i = 0; data_ready_i = 0;
        //          rst en sy b bv rdy  valid cnt ovf
        tbl[0] = '{1, 0, 0, 0, 0, 0,   0, 6'd0, 0};
        tbl[1] = '{0, 1, 0, 1, 1, 0,   0, 6'd0, 0};  // still idle: bit ignored
        tbl[2] = '{0, 1, 0, 1, 1, 0,   0, 6'd1, 0};
        tbl[3] = '{0, 1, 0, 0, 0, 0,   0, 6'd1, 0};
        tbl[4] = '{0, 1, 1, 1, 1, 0,   0, 6'd0, 0};  // sync drops partial and this bit
        tbl[5] = '{0, 1, 0, 0, 1, 0,   0, 6'd1, 0};
        tbl[6] = '{0, 0, 0, 1, 1, 0,   0, 6'd0, 0};  // disable discards
        tbl[7] = '{0, 1, 0, 1, 1, 0,   0, 6'd0, 0};
        tbl[8] = '{0, 1, 0, 1, 1, 0,   0, 6'd1, 0};
        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; en_i = tbl[i].en; sync_i = tbl[i].sync;
            bit_i = tbl[i].b; bit_valid_i = tbl[i].bv; data_ready_i = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_valid", i), 64'(data_valid_o), 64'(tbl[i].valid));
            check($sformatf("tbl%0d_cnt", i), 64'(bit_cnt_o), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_ovf", i), 64'(overflow_o), 64'(tbl[i].ovf));
            if (i == 0) begin
                check("reset_data", 64'(data_o), 64'd0);
                check("reset_words", 64'(words_o), 64'd0);
            end
        end

        // Single word with ready high: valid for exactly one cycle.
        do_reset();
        en_i = 1; data_ready_i = 1;
        tick();
        shift_word(WordA);
        check("t1_valid", 64'(data_valid_o), 64'd1);
        check("t1_data", 64'(data_o), 64'(WordA));
        check("t1_words", 64'(words_o), 64'd1);
        check("t1_cnt", 64'(bit_cnt_o), 64'd0);
        tick();
        check("t1_valid_gone", 64'(data_valid_o), 64'd0);

        // Back-to-back words held, then popped on consecutive cycles.
        do_reset();
        en_i = 1; data_ready_i = 0;
        tick();
        shift_word(WordA);
        shift_word(WordB);
        check("t2_head", 64'(data_o), 64'(WordA));
        data_ready_i = 1;
        tick();
        check("t2_second", 64'(data_o), 64'(WordB));
        check("t2_valid2", 64'(data_valid_o), 64'd1);
        tick();
        check("t2_empty", 64'(data_valid_o), 64'd0);
        check("t2_ovf", 64'(overflow_o), 64'd0);

        // Five words into a 4-deep FIFO: fifth dropped.
        do_reset();
        en_i = 1; data_ready_i = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            w[k] = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
            shift_word(w[k]);
        end
        check("t3_words", 64'(words_o), 64'd4);
        check("t3_ovf", 64'(overflow_o), 64'd1);
        data_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_drain%0d", k), 64'(data_o), 64'(w[k]));
            tick();
        end
        check("t3_empty", 64'(data_valid_o), 64'd0);

        // Full FIFO, last bit of a new word coincides with a pop.
        do_reset();
        en_i = 1; data_ready_i = 0;
        tick();
        for (int k = 0; k < 5; k++) w[k] = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
        for (int k = 0; k < 4; k++) shift_word(w[k]);
        bit_valid_i = 1;
        for (int i = 39; i >= 1; i--) begin
            bit_i = w[4][i];
            tick();
        end
        bit_i = w[4][0]; data_ready_i = 1;
        tick();
        bit_valid_i = 0;
        check("t4_ovf", 64'(overflow_o), 64'd0);
        check("t4_words", 64'(words_o), 64'd5);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("t4_drain%0d", k), 64'(data_o), 64'(w[k]));
            tick();
        end
        check("t4_empty", 64'(data_valid_o), 64'd0);

        // Sync in the middle of a word.
        do_reset();
        en_i = 1; data_ready_i = 0;
        tick();
        bit_valid_i = 1;
        for (int i = 0; i < 17; i++) begin
            bit_i = 1'($urandom);
            tick();
        end
        sync_i = 1; bit_i = 1;
        tick();
        sync_i = 0;
        check("t5_cnt_after_sync", 64'(bit_cnt_o), 64'd0);
        shift_word(WordB);
        check("t5_data", 64'(data_o), 64'(WordB));
        check("t5_words", 64'(words_o), 64'd1);

        // Disable after 20 bits, re-enable, full word.
        do_reset();
        en_i = 1; data_ready_i = 0;
        tick();
        bit_valid_i = 1;
        for (int i = 0; i < 20; i++) begin
            bit_i = 1'($urandom);
            tick();
        end
        bit_valid_i = 0; en_i = 0;
        tick();
        en_i = 1;
        tick();
        shift_word(WordA);
        check("t6_data", 64'(data_o), 64'(WordA));
        check("t6_words", 64'(words_o), 64'd1);

        // Reset with two words queued.
        shift_word(WordB);
        rst = 1;
        tick();
        rst = 0;
        check("t6_rst_valid", 64'(data_valid_o), 64'd0);
        check("t6_rst_words", 64'(words_o), 64'd0);

        // Random traffic with varying downstream pressure.
        for (int blk = 0; blk < 16; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                rst          = ($urandom_range(0, 999) == 0);
                en_i         = ($urandom_range(0, 99) < 97);
                sync_i       = ($urandom_range(0, 199) == 0);
                bit_valid_i  = ($urandom_range(0, 99) < 85);
                bit_i        = 1'($urandom);
                data_ready_i = ($urandom_range(0, 99) < rdy_pct);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmu_bitstream_word_assembler.md
# pmu_bitstream_word_assembler

Serial-to-parallel front end of the PMU. It receives the configuration bitstream one bit per qualified clock, MSB first, and packs the bits into 40-bit words. Completed words go into a small FIFO and are presented to `address_generator` on `data_o` with a valid/ready handshake, so a stalled downstream stage does not lose bits already in flight. It also reports framing status: the partial bit count, a saturating count of completed words, and a sticky overflow flag.

## Interface
- `WORD_WIDTH`, 40, bits per assembled word. Must match the `address_generator` input width.
- `FIFO_DEPTH`, 4, number of word entries. Must be a power of 2 and at least 2.
- `CNT_WIDTH`, 16, width of the `words_o` counter.

Ports:
- `clk`  in  1  single clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `en_i`  in  1  assembler enable. Low forces IDLE.
- `sync_i`  in  1  word-alignment pulse. Discards any partial word.
- `bit_i`  in  1  serial bitstream bit.
- `bit_valid_i`  in  1  `bit_i` is qualified this cycle.
- `data_o`  out  WORD_WIDTH  FIFO head word. Feeds `address_generator.data_i`.
- `data_valid_o`  out  1  FIFO not empty.
- `data_ready_i`  in  1  downstream accepts `data_o`.
- `bit_cnt_o`  out  6  number of bits held in the partial word (0..39).
- `words_o`  out  CNT_WIDTH  number of words pushed into the FIFO. Saturates at all-ones.
- `overflow_o`  out  1  sticky: a completed word was dropped because the FIFO was full.

## Operation
- FSM states:
  - IDLE: shift register and bit counter are held at 0.
  - ASSEMBLE: shifting is active.
- Transitions:
  - IDLE→ASSEMBLE when `en_i`=1.
  - ASSEMBLE→IDLE when `en_i`=0. The partial word is discarded; the FIFO contents and its draining are unaffected.
- Shifting in ASSEMBLE, when `bit_valid_i`=1: `shreg <= {shreg[38:0], bit_i}`, then `bit_cnt` increments. The first bit received ends up in `data_o[39]`.
- Word completion: on the edge that accepts the 40th bit, `{shreg[38:0], bit_i}` is pushed into the FIFO and `bit_cnt` returns to 0.
- `sync_i`=1 in ASSEMBLE:
  - `bit_cnt` and `shreg` are cleared.
  - Any `bit_valid_i` on the same cycle is discarded.
  - `sync_i` has priority over word completion.
- FIFO:
  - Circular buffer with a read pointer, a write pointer and an occupancy counter (0..FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
  - `data_o` = `mem[rd_ptr]`. Pop occurs when `data_valid_o`=1 and `data_ready_i`=1.
- Push while full:
  - With a pop on the same cycle, the push succeeds and occupancy is unchanged.
  - Without a pop, the word is dropped, `overflow_o` is set, and `words_o` does not increment.
- Push and pop on the same cycle with the FIFO not full: both happen and occupancy is unchanged.
- `words_o` increments on every successful push and saturates at 2^CNT_WIDTH−1.
- `overflow_o` is cleared only by `rst`.
- `data_ready_i` while empty: no effect. Pointers do not move.

## Timing
- Reset values:
  - outputs: `data_o`=0, `data_valid_o`=0, `bit_cnt_o`=0, `words_o`=0, `overflow_o`=0
  - internal: state=IDLE, pointers 0
- `rst` asserted mid-word or with the FIFO non-empty: all contents are lost. Outputs take their reset values on the next edge.
- Latency: the edge accepting the 40th bit writes the FIFO. `data_valid_o`=1 and `data_o` are valid from that edge, i.e. in the cycle after the bit is presented.
- `en_i` rising: the first bit can be accepted one cycle later, once the FSM is in ASSEMBLE.
- `data_o` is stable while `data_valid_o`=1 and `data_ready_i`=0.
- After a pop, the next entry appears the following cycle.
- Throughput: one bit per clock. The FIFO drains at one word per clock.
- All outputs are registered or derived directly from registers. There is no combinational path from `data_ready_i` to any output.

## Test plan
- Reset, then `en_i`=1, `data_ready_i`=1, shift 40'h0000C000AA MSB first → `data_valid_o`=1 for exactly one cycle, `data_o`=40'h0000C000AA, `words_o`=1, `bit_cnt_o`=0.
- Back-to-back words 40'h0000C000AA then 40'hC000000710 with no gap, `data_ready_i`=0 → both held in order; raising `data_ready_i` pops them on consecutive cycles; `overflow_o`=0.
- `data_ready_i`=0, push 5 words → first 4 retained, 5th dropped, `overflow_o`=1, `words_o`=4; draining yields words 1–4 only.
- FIFO full and the 40th bit of a new word arrives in the same cycle as a pop → word accepted, occupancy stays 4, `overflow_o` stays 0.
- Shift 17 bits, pulse `sync_i` together with a valid bit, then shift 40'hC000000710 → `bit_cnt_o`=0 after the sync; output word is exactly 40'hC000000710.
- Drop `en_i` after 20 bits, re-enable, and shift a full word → only the new word is emitted. Separately, assert `rst` while the FIFO holds 2 words → `data_valid_o`=0, `words_o`=0 on the next cycle.
